// File: rtl/periph_req_buffer_pkg.sv
// Shared cluster peripheral package.
// Holds the default request payload layout and the default buffer sizing
// used by periph_req_buffer and its request FIFO, plus a small helper
// that advances a circular pointer whose modulus need not be a power of 2.
package periph_req_buffer_pkg;

  localparam int PERIPH_ADDR_WIDTH      = 32;
  localparam int PERIPH_DATA_WIDTH      = 32;
  localparam int PERIPH_BE_WIDTH        = PERIPH_DATA_WIDTH / 8;
  localparam int PERIPH_FIFO_DEPTH      = 2;
  localparam int PERIPH_MAX_OUTSTANDING = 4;

  // Request payload at the default widths. periph_req_buffer builds the
  // same field layout at its own parameterised widths.
  typedef struct packed {
    logic [PERIPH_ADDR_WIDTH-1:0] add;
    logic                         wen;
    logic [PERIPH_DATA_WIDTH-1:0] wdata;
    logic [PERIPH_BE_WIDTH-1:0]   be;
  } periph_req_t;

  // Next position of a pointer that wraps modulo depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/periph_req_fifo.sv
// In-order request FIFO, generic over payload type and depth.
// Ports:
//   clk, rst_ni  - clock, asynchronous active-low reset
//   push_i       - write data_i (ignored when full)
//   data_i       - payload to store
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - current head entry (undefined content when empty)
//   count_o      - occupancy, 0..DEPTH; the owner derives full/empty from it
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of 2.
module periph_req_fifo
  import periph_req_buffer_pkg::*;
#(
  parameter type T     = periph_req_t,
  parameter int  DEPTH = PERIPH_FIFO_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return PW'(wrap_inc(32'(p), DEPTH));
  endfunction

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written,
  // and the owner masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/periph_req_buffer.sv
// Request buffer between the core data port and the peripheral demux.
// Requests are queued in an in-order FIFO so that the core-side grant is
// a pure function of registered state (full/outstanding), cutting the
// combinational gnt path through the demux. Responses pass straight
// through; a response with nothing outstanding is dropped and flagged.
// Ports:
//   clk, rst_ni          - clock, asynchronous active-low reset
//   data_req_i .. be_i   - core-side request
//   data_gnt_o           - core-side grant (registered state only)
//   data_r_valid_o/rdata_o/opc_o - core-side response (combinational)
//   data_req_o .. be_o   - FIFO head toward the demux, zero when empty
//   data_gnt_i           - demux grant, pops the head
//   data_r_valid_i/rdata_i/opc_i - demux response
//   err_o                - sticky flag: response seen with none outstanding
// Handshake: a transfer happens in a cycle where req and gnt are both 1;
// while req is 1 and gnt is 0 the offered fields stay stable. Responses
// return in request order and are counted, not matched by id.
module periph_req_buffer
  import periph_req_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH      = PERIPH_ADDR_WIDTH,
  parameter int DATA_WIDTH      = PERIPH_DATA_WIDTH,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH      = PERIPH_FIFO_DEPTH,      // 2..8
  parameter int MAX_OUTSTANDING = PERIPH_MAX_OUTSTANDING  // FIFO_DEPTH..15
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  // core side
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  // demux side
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  // status
  output logic                  err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  req_t          push_data;
  req_t          head;
  req_t          head_vis;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          rsp_ok;
  logic          rsp_spurious;
  logic [OW-1:0] outstanding_q;
  logic          live_q;
  logic          err_q;

  assign push_data = '{add: data_add_i, wen: data_wen_i,
                       wdata: data_wdata_i, be: data_be_i};

  periph_req_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));

  // live_q is low in reset and rises on the first edge after release, so
  // the grant stays low while held in reset yet comes only from flops.
  assign data_gnt_o = live_q && !fifo_full &&
                      (outstanding_q < OW'(MAX_OUTSTANDING));

  assign push = data_req_i && data_gnt_o;
  assign pop  = data_req_o && data_gnt_i;

  assign rsp_ok       = data_r_valid_i && (outstanding_q != '0);
  assign rsp_spurious = data_r_valid_i && (outstanding_q == '0);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      live_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (rsp_spurious) err_q <= 1'b1;
      case ({push, rsp_ok})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Head fields are forced to zero while empty so the demux never sees
  // stale or uninitialised storage.
  assign head_vis     = fifo_empty ? '0 : head;
  assign data_req_o   = !fifo_empty;
  assign data_add_o   = head_vis.add;
  assign data_wen_o   = head_vis.wen;
  assign data_wdata_o = head_vis.wdata;
  assign data_be_o    = head_vis.be;

  assign data_r_valid_o = rsp_ok;
  assign data_r_rdata_o = data_r_rdata_i;
  assign data_r_opc_o   = data_r_opc_i;

  assign err_o = err_q;

endmodule

// File: tb/tb_periph_req_buffer.sv
// Testbench for periph_req_buffer: a directed vector table, randomised
// traffic against a queue-based reference model, and hand sequences for
// back-to-back traffic and reset in the middle of operation.
module tb_periph_req_buffer;

  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        data_req_i, data_wen_i, data_gnt_o;
  logic [31:0] data_add_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_r_valid_o, data_r_opc_o;
  logic [31:0] data_r_rdata_o;
  logic        data_req_o, data_wen_o;
  logic [31:0] data_add_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i, data_r_valid_i, data_r_opc_i;
  logic [31:0] data_r_rdata_i;
  logic        err_o;

  periph_req_buffer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
    .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o(data_r_opc_o),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
    .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_gnt_i(data_gnt_i),
    .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
    .data_r_opc_i(data_r_opc_i),
    .err_o(err_o)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } m_req_t;

  m_req_t      m_q[$];      // requests buffered, oldest first
  logic [31:0] exp_q[$];    // read data owed by the peripheral, in order
  int          m_out;       // accepted, not yet answered
  bit          m_err;
  bit          m_live;      // first edge after reset has occurred
  bit          e_gnt, e_req;
  int          n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and check the
  // outputs against the model before the rising edge.
  task automatic apply(input logic req, input logic [31:0] add,
                       input logic wen, input logic [31:0] wd,
                       input logic [3:0] be, input logic gi, input logic rv,
                       input logic [31:0] rd, input logic opc);
    m_req_t h;
    data_req_i = req; data_add_i = add; data_wen_i = wen;
    data_wdata_i = wd; data_be_i = be; data_gnt_i = gi;
    data_r_valid_i = rv; data_r_rdata_i = rd; data_r_opc_i = opc;
    #2;
    e_gnt = m_live && (m_q.size() < DEPTH) && (m_out < MAX_OUT);
    e_req = (m_q.size() != 0);
    h = e_req ? m_q[0] : '0;
    chk("gnt_o",      32'(data_gnt_o),     32'(e_gnt));
    chk("req_o",      32'(data_req_o),     32'(e_req));
    chk("add_o",      data_add_o,          h.add);
    chk("wen_o",      32'(data_wen_o),     32'(h.wen));
    chk("wdata_o",    data_wdata_o,        h.wdata);
    chk("be_o",       32'(data_be_o),      32'(h.be));
    chk("r_valid_o",  32'(data_r_valid_o), 32'(rv && (m_out > 0)));
    chk("r_rdata_o",  data_r_rdata_o,      rd);
    chk("r_opc_o",    32'(data_r_opc_o),   32'(opc));
    chk("err_o",      32'(err_o),          32'(m_err));
    chk("fifo_count", 32'(dut.fifo_cnt),   32'(m_q.size()));
    chk("outstanding",32'(dut.outstanding_q), 32'(m_out));
  endtask

  task automatic finish_cycle();
    bit push, pop;
    @(posedge clk);
    push = data_req_i && e_gnt;
    pop  = e_req && data_gnt_i;
    if (pop) exp_q.push_back(m_q.pop_front().add ^ 32'h5A5A_5A5A);
    if (push) m_q.push_back('{add: data_add_i, wen: data_wen_i,
                              wdata: data_wdata_i, be: data_be_i});
    if (data_r_valid_i) begin
      if (m_out > 0) m_out--;
      else m_err = 1'b1;
    end
    if (push) m_out++;
    m_live = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    apply(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    finish_cycle();
  endtask

  // Entered and left on a falling edge; reset is held across one rising edge.
  task automatic reset_seq();
    rst_ni = 1'b0;
    data_req_i = 0; data_add_i = '0; data_wen_i = 0; data_wdata_i = '0;
    data_be_i = '0; data_gnt_i = 0; data_r_valid_i = 0; data_r_rdata_i = '0;
    data_r_opc_i = 0;
    #2;
    chk("rst req_o",   32'(data_req_o),  32'd0);
    chk("rst gnt_o",   32'(data_gnt_o),  32'd0);
    chk("rst err_o",   32'(err_o),       32'd0);
    chk("rst add_o",   data_add_o,       32'd0);
    chk("rst wdata_o", data_wdata_o,     32'd0);
    chk("rst be_o",    32'(data_be_o),   32'd0);
    chk("rst wen_o",   32'(data_wen_o),  32'd0);
    chk("rst count",   32'(dut.fifo_cnt), 32'd0);
    chk("rst outst",   32'(dut.outstanding_q), 32'd0);
    m_q.delete(); exp_q.delete();
    m_out = 0; m_err = 0; m_live = 0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic [31:0] wd;
    logic        gi;
    logic        rv;
    logic [31:0] rd;
    logic        e_gnt;
    logic        e_req;
    logic [31:0] e_add;
    logic [31:0] e_wd;
    logic        e_rv;
    logic        e_err;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic logic [31:0] fa(input int i); return 32'h1000 + 32'(i * 4); endfunction
  function automatic logic [31:0] fd(input int i); return 32'hC0DE_0000 + 32'(i); endfunction
  function automatic logic [31:0] fr(input int i); return 32'hB0B0_0000 + 32'(i); endfunction

  function automatic vec_t mk(input logic req, input logic [31:0] add,
                              input logic [31:0] wd, input logic gi,
                              input logic rv, input logic [31:0] rd,
                              input logic eg, input logic er,
                              input logic [31:0] ea, input logic [31:0] ew,
                              input logic erv, input logic ee);
    return '{req: req, add: add, wd: wd, gi: gi, rv: rv, rd: rd,
             e_gnt: eg, e_req: er, e_add: ea, e_wd: ew, e_rv: erv, e_err: ee};
  endfunction

  logic [31:0] r_add, r_wd, r_rd;
  logic        r_req, r_gi, r_rv, r_opc, r_wen;
  logic [3:0]  r_be;
  int          guard;

  initial begin
    n_vec = 0; n_err = 0;

    // backpressure: two accepted, third held off, head stable
    tbl[0]  = mk(1, fa(0), fd(0), 0, 0, 0,        1, 0, 0,     0,     0, 0);
    tbl[1]  = mk(1, fa(1), fd(1), 0, 0, 0,        1, 1, fa(0), fd(0), 0, 0);
    tbl[2]  = mk(1, fa(2), fd(2), 0, 0, 0,        0, 1, fa(0), fd(0), 0, 0);
    tbl[3]  = mk(1, fa(2), fd(2), 0, 0, 0,        0, 1, fa(0), fd(0), 0, 0);
    tbl[4]  = mk(0, 0,     0,     1, 0, 0,        0, 1, fa(0), fd(0), 0, 0);
    tbl[5]  = mk(0, 0,     0,     1, 0, 0,        1, 1, fa(1), fd(1), 0, 0);
    tbl[6]  = mk(0, 0,     0,     0, 1, fr(0),    1, 0, 0,     0,     1, 0);
    tbl[7]  = mk(0, 0,     0,     0, 1, fr(1),    1, 0, 0,     0,     1, 0);
    // outstanding limit with responses withheld
    tbl[8]  = mk(1, fa(3), fd(3), 1, 0, 0,        1, 0, 0,     0,     0, 0);
    tbl[9]  = mk(1, fa(4), fd(4), 1, 0, 0,        1, 1, fa(3), fd(3), 0, 0);
    tbl[10] = mk(1, fa(5), fd(5), 1, 0, 0,        1, 1, fa(4), fd(4), 0, 0);
    tbl[11] = mk(1, fa(6), fd(6), 1, 0, 0,        1, 1, fa(5), fd(5), 0, 0);
    tbl[12] = mk(1, fa(7), fd(7), 1, 0, 0,        0, 1, fa(6), fd(6), 0, 0);
    tbl[13] = mk(1, fa(7), fd(7), 1, 1, fr(2),    0, 0, 0,     0,     1, 0);
    tbl[14] = mk(1, fa(7), fd(7), 1, 0, 0,        1, 0, 0,     0,     0, 0);
    tbl[15] = mk(0, 0,     0,     1, 1, fr(3),    0, 1, fa(7), fd(7), 1, 0);
    tbl[16] = mk(0, 0,     0,     0, 1, fr(4),    1, 0, 0,     0,     1, 0);
    tbl[17] = mk(0, 0,     0,     0, 1, fr(5),    1, 0, 0,     0,     1, 0);
    tbl[18] = mk(0, 0,     0,     0, 1, fr(6),    1, 0, 0,     0,     1, 0);
    // spurious response: dropped, error sticky
    tbl[19] = mk(0, 0,     0,     0, 1, 32'hDEADBEEF, 1, 0, 0, 0,     0, 0);
    tbl[20] = mk(0, 0,     0,     0, 0, 0,        1, 0, 0,     0,     0, 1);
    tbl[21] = mk(0, 0,     0,     0, 0, 0,        1, 0, 0,     0,     0, 1);

    @(negedge clk);
    reset_seq();
    idle_cycle();

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].req, tbl[i].add, 1'b1, tbl[i].wd, 4'hF, tbl[i].gi,
            tbl[i].rv, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d gnt_o", i),   32'(data_gnt_o),     32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d req_o", i),   32'(data_req_o),     32'(tbl[i].e_req));
      chk($sformatf("tbl%0d add_o", i),   data_add_o,          tbl[i].e_add);
      chk($sformatf("tbl%0d wdata_o", i), data_wdata_o,        tbl[i].e_wd);
      chk($sformatf("tbl%0d r_valid_o", i), 32'(data_r_valid_o), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d err_o", i),   32'(err_o),          32'(tbl[i].e_err));
      finish_cycle();
    end

    // randomised traffic; the peripheral answers only requests it has seen
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      r_req = ($urandom_range(0, 3) != 0);
      r_add = $urandom(); r_wd = $urandom(); r_wen = 1'($urandom_range(0, 1));
      r_be  = 4'($urandom_range(0, 15));
      r_gi  = ($urandom_range(0, 2) != 0);
      r_opc = 1'($urandom_range(0, 1));
      r_rv  = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
      r_rd  = r_rv ? exp_q.pop_front() : $urandom();
      apply(r_req, r_add, r_wen, r_wd, r_be, r_gi, r_rv, r_rd, r_opc);
      finish_cycle();
    end

    // drain everything still in flight
    guard = 0;
    while ((m_out != 0) && (guard < 40)) begin
      r_rv = (exp_q.size() != 0);
      r_rd = r_rv ? exp_q.pop_front() : 32'h0;
      apply(0, 32'h0, 0, 32'h0, 4'h0, 1, r_rv, r_rd, 0);
      finish_cycle();
      guard++;
    end
    chk("drain", 32'(m_out), 32'd0);

    // reset with two requests buffered
    apply(1, 32'h2000, 1, 32'h1111_1111, 4'h3, 0, 0, 32'h0, 0);
    finish_cycle();
    apply(1, 32'h2004, 0, 32'h2222_2222, 4'hC, 0, 0, 32'h0, 0);
    finish_cycle();
    chk("pre-reset count", 32'(dut.fifo_cnt), 32'd2);
    reset_seq();
    idle_cycle();   // grant still low before the first edge after release
    idle_cycle();   // grant high afterwards

    // back-to-back: 4 requests, responses one cycle after each pop
    for (int k = 0; k < 8; k++) begin
      r_rv = (exp_q.size() != 0);
      r_rd = r_rv ? exp_q.pop_front() : 32'h0;
      apply(k < 4, 32'h3000 + 32'(k * 4), 1'(k & 1), 32'hA5A5_0000 + 32'(k),
            4'hF, 1, r_rv, r_rd, 0);
      finish_cycle();
    end
    chk("b2b outstanding", 32'(dut.outstanding_q), 32'd0);
    chk("b2b err_o", 32'(err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
